core_memory_arbiter: RTL

Shares the core's single memory port between the instruction-fetch requester (pipe fetch stage) and the data requester (load/store stage). It registers a grant, steers address, control and write data from the granted requester to the memory bus, and returns busy and read data to each side. Ties are broken round-robin, and a watchdog aborts memory transactions that stall too long. It sits between the pipeline stages and the core's memory/wishbone master.

---
 rtl/core_memory_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/core_memory_arbiter.sv
// Two-requester arbiter for the core's single memory port: instruction fetch vs load/store.
// Round-robin tie break, one IDLE cycle between accesses, and a busy-cycle watchdog.
module core_memory_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetchAddress,
    input  logic        fetchEnable,
    output logic        fetchBusy,
    output logic [31:0] fetchReadData,
    input  logic [31:0] dataAddress,
    input  logic [3:0]  dataByteSelect,
    input  logic        dataWriteEnable,
    input  logic [31:0] dataWriteData,
    input  logic        dataEnable,
    output logic        dataBusy,
    output logic [31:0] dataReadData,
    output logic [31:0] memAddress,
    output logic [3:0]  memByteSelect,
    output logic        memWriteEnable,
    output logic [31:0] memWriteData,
    output logic        memEnable,
    input  logic        memBusy,
    input  logic [31:0] memReadData,
    output logic        grantFetch,
    output logic        grantData,
    output logic        busTimeout
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t      state, stateNext;
    logic        lastGrantData, lastGrantDataNext;
    logic [15:0] busyCount;
    logic        grantedEnable, complete, timeoutHit;

    assign grantedEnable = (state == FETCH) ? fetchEnable :
                           (state == DATA)  ? dataEnable  : 1'b0;
    assign complete      = grantedEnable && !memBusy;
    // An abort (enable dropped) takes priority, so the watchdog only fires on a live request.
    assign timeoutHit    = (TIMEOUT_CYCLES != 16'd0) && grantedEnable && memBusy &&
                           (busyCount == TIMEOUT_CYCLES - 16'd1);

    always_comb begin
        stateNext         = state;
        lastGrantDataNext = lastGrantData;
        memAddress        = 32'h0;
        memByteSelect     = 4'h0;
        memWriteEnable    = 1'b0;
        memWriteData      = 32'h0;
        memEnable         = 1'b0;
        case (state)
            IDLE: begin
                if (dataEnable && (!fetchEnable || !lastGrantData)) begin
                    stateNext         = DATA;
                    lastGrantDataNext = 1'b1;
                end else if (fetchEnable) begin
                    stateNext         = FETCH;
                    lastGrantDataNext = 1'b0;
                end
            end
            FETCH: begin
                memAddress    = fetchAddress;
                memByteSelect = 4'hF;
                memEnable     = fetchEnable;
                if (!grantedEnable || complete || timeoutHit) stateNext = IDLE;
            end
            DATA: begin
                memAddress     = dataAddress;
                memByteSelect  = dataByteSelect;
                memWriteEnable = dataWriteEnable;
                memWriteData   = dataWriteData;
                memEnable      = dataEnable;
                if (!grantedEnable || complete || timeoutHit) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lastGrantData <= 1'b0;
            busyCount     <= 16'h0;
            busTimeout    <= 1'b0;
        end else begin
            state         <= stateNext;
            lastGrantData <= lastGrantDataNext;
            busTimeout    <= timeoutHit;
            // Every grant is entered from IDLE, so clearing there clears on entry.
            if (state == IDLE)
                busyCount <= 16'h0;
            else if (memBusy && busyCount != 16'hFFFF)
                busyCount <= busyCount + 16'd1;
        end
    end

    assign grantFetch    = (state == FETCH);
    assign grantData     = (state == DATA);
    assign fetchBusy     = !(grantFetch && complete);
    assign dataBusy      = !(grantData && complete);
    assign fetchReadData = memReadData;
    assign dataReadData  = memReadData;

endmodule
